// File: rtl/simram_pkg.sv
// simram_pkg: shared types, limits and helpers for the simram_bank RAM model.
// The parity helper is only called when SIMRAM_PARITY_EN is defined.
package simram_pkg;

  // Sequencer states: sweeping the array with the fill value, or serving requests.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Deepest supported read latency.
  localparam int RD_LAT_MAX = 4;

  // Widest data word the parity helper accepts.
  localparam int PAR_MAX_W  = 256;

  // Even parity: the returned bit makes the total number of ones even.
  // Narrower words are zero-extended by the caller, which leaves the result unchanged.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/simram_rd_pipe.sv
// simram_rd_pipe: read-return delay line with clock enable.
// Stage 0 captures the array sample on the acceptance edge.
// The remaining STAGES-1 stages add the extra read latency.
// Data bits hold their last valid value, so the final stage doubles as the rd_data hold register.
// The two flag bits clear whenever no read is present, so they only pulse with valid.
module simram_rd_pipe
  import simram_pkg::*;
#(
  parameter int              DATA_W     = 16,
  parameter int              STAGES     = 1,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [DATA_W+1:0] bus_i,
  output logic              valid_o,
  output logic [DATA_W+1:0] bus_o
);

  logic [STAGES-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [STAGES];
  logic [1:0]        flg_q [STAGES];

  // Shift the valid/flag/data stages; everything freezes while en_i is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        dat_q[i] <= RESET_DATA;
        flg_q[i] <= 2'b00;
      end
    end else if (en_i) begin
      vld_q[0] <= valid_i;
      flg_q[0] <= valid_i ? bus_i[DATA_W+1:DATA_W] : 2'b00;
      if (valid_i) begin
        dat_q[0] <= bus_i[DATA_W-1:0];
      end
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        flg_q[i] <= vld_q[i-1] ? flg_q[i-1] : 2'b00;
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign valid_o = vld_q[STAGES-1];
  assign bus_o   = {flg_q[STAGES-1], dat_q[STAGES-1]};

endmodule

// File: rtl/simram_bank.sv
// simram_bank: behavioural word RAM with the following features:
//   - byte-enabled writes;
//   - a req/ready handshake;
//   - a configurable read latency;
//   - a hardware clear sequencer that runs after reset or on clear_i.
// Optional feature: define SIMRAM_PARITY_EN to store one even-parity bit per word.
//   - err_inject_i can corrupt the stored parity bit on a write.
//   - Mismatches are reported on parity_err_o.
module simram_bank
  import simram_pkg::*;
#(
  parameter int              DATA_W     = 16,
  parameter int              ADDR_W     = 8,
  parameter int              DEPTH      = 256,
  parameter int              RD_LAT     = 1,
  parameter logic [DATA_W-1:0] FILL_VALUE = 16'hAAA3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clk_en_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic                clear_i,
  input  logic                err_inject_i,
  output logic                ready_o,
  output logic                busy_o,
  output logic                rd_valid_o,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                oor_err_o,
  output logic                parity_err_o
);

  localparam int BE_W = DATA_W / 8;
  // Clamp the latency into the range the pipeline supports.
  localparam int LAT  = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc_s;
  logic              in_range_s;
  logic [DATA_W-1:0] cur_word_s;
  logic [DATA_W-1:0] merged_s;
  logic              par_flag_s;

  assign ready_o    = (state_q == ST_IDLE) && !clear_i;
  assign busy_o     = (state_q == ST_CLEAR);
  assign acc_s      = req_i && ready_o && clk_en_i;
  assign in_range_s = ({1'b0, addr_i} < (ADDR_W+1)'(DEPTH));

  // Current word at addr_i, plus the byte-merged word that a write would store.
  always_comb begin
    cur_word_s = FILL_VALUE;
    merged_s   = FILL_VALUE;
    if (in_range_s) begin
      cur_word_s = mem_q[addr_i];
    end else begin
      cur_word_s = FILL_VALUE;
    end
    for (int k = 0; k < BE_W; k++) begin
      if (be_i[k]) begin
        merged_s[8*k +: 8] = wr_data_i[8*k +: 8];
      end else begin
        merged_s[8*k +: 8] = cur_word_s[8*k +: 8];
      end
    end
  end

  // Sequencer: sweep every word in CLEAR, then serve requests in IDLE until the next clear_i.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else if (clk_en_i) begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            clr_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clear_i) begin
            state_q <= ST_CLEAR;
          end
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_cnt_q <= '0;
        end
      endcase
    end
  end

  // Word storage (not reset): writes come from the clear sweep or from accepted in-range writes.
  always_ff @(posedge clock) begin
    if (clk_en_i) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_cnt_q] <= FILL_VALUE;
      end else if (acc_s && we_i && in_range_s) begin
        mem_q[addr_i] <= merged_s;
      end
    end
  end

`ifdef SIMRAM_PARITY_EN
  logic par_mem_q [DEPTH];
  logic stored_par_s;

  // Compare the recomputed parity of the addressed word with its stored bit.
  // Out-of-range reads never flag.
  always_comb begin
    stored_par_s = 1'b0;
    par_flag_s   = 1'b0;
    if (in_range_s) begin
      stored_par_s = par_mem_q[addr_i];
      par_flag_s   = (even_parity(PAR_MAX_W'(cur_word_s)) != stored_par_s);
    end else begin
      stored_par_s = 1'b0;
      par_flag_s   = 1'b0;
    end
  end

  // Parity storage tracks the word array; err_inject_i flips the bit on a write.
  always_ff @(posedge clock) begin
    if (clk_en_i) begin
      if (state_q == ST_CLEAR) begin
        par_mem_q[clr_cnt_q] <= even_parity(PAR_MAX_W'(FILL_VALUE));
      end else if (acc_s && we_i && in_range_s) begin
        par_mem_q[addr_i] <= even_parity(PAR_MAX_W'(merged_s)) ^ err_inject_i;
      end
    end
  end
`else
  logic unused_err_inject_s;
  assign unused_err_inject_s = err_inject_i;
  assign par_flag_s          = 1'b0;
`endif

  simram_rd_pipe #(
    .DATA_W     (DATA_W),
    .STAGES     (LAT),
    .RESET_DATA (FILL_VALUE)
  ) u_rd_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (clk_en_i),
    .valid_i (acc_s && !we_i),
    .bus_i   ({par_flag_s, !in_range_s, cur_word_s}),
    .valid_o (rd_valid_o),
    .bus_o   ({parity_err_o, oor_err_o, rd_data_o})
  );

endmodule

// File: tb/tb_simram_bank.sv
// Scoreboard bench for simram_bank.
// Instance A uses the default parameters: DEPTH=256, RD_LAT=1.
// Instance B uses DEPTH=200, RD_LAT=3.
// Reads push expected data, flags and arrival cycle into a per-instance queue.
// Monitors pop and compare whenever rd_valid_o is seen.
module tb_simram_bank;

  localparam logic [15:0] FILL = 16'hAAA3;
`ifdef SIMRAM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic a_en, a_req, a_we, a_clr, a_inj;
  logic [7:0] a_addr;
  logic [15:0] a_wd, a_rd;
  logic [1:0] a_be;
  logic a_ready, a_busy, a_rv, a_oor, a_par;

  logic b_en, b_req, b_we, b_clr, b_inj;
  logic [7:0] b_addr;
  logic [15:0] b_wd, b_rd;
  logic [1:0] b_be;
  logic b_ready, b_busy, b_rv, b_oor, b_par;

  simram_bank u_dut_a (
    .clock(clock), .reset_n(reset_n), .clk_en_i(a_en), .req_i(a_req), .we_i(a_we),
    .addr_i(a_addr), .wr_data_i(a_wd), .be_i(a_be), .clear_i(a_clr), .err_inject_i(a_inj),
    .ready_o(a_ready), .busy_o(a_busy), .rd_valid_o(a_rv), .rd_data_o(a_rd),
    .oor_err_o(a_oor), .parity_err_o(a_par));

  simram_bank #(.DEPTH(200), .RD_LAT(3)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .clk_en_i(b_en), .req_i(b_req), .we_i(b_we),
    .addr_i(b_addr), .wr_data_i(b_wd), .be_i(b_be), .clear_i(b_clr), .err_inject_i(b_inj),
    .ready_o(b_ready), .busy_o(b_busy), .rd_valid_o(b_rv), .rd_data_o(b_rd),
    .oor_err_o(b_oor), .parity_err_o(b_par));

  typedef struct {
    logic [15:0] d;
    logic        oor;
    logic        par;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (a_rv) begin
      exp_t e;
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_valid: got data %0h want no read", a_rd);
      end else begin
        e = q_a.pop_front();
        chk("a_data", a_rd, e.d);
        chk("a_oor", a_oor, e.oor);
        chk("a_par", a_par, e.par);
        chk("a_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clock) begin
    if (b_rv) begin
      exp_t e;
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_valid: got data %0h want no read", b_rd);
      end else begin
        e = q_b.pop_front();
        chk("b_data", b_rd, e.d);
        chk("b_oor", b_oor, e.oor);
        chk("b_par", b_par, e.par);
        chk("b_latency", cyc, e.due);
      end
    end
  end

  task automatic drive(input bit b, input bit we, input logic [7:0] addr, input logic [15:0] wd,
                       input logic [1:0] be, input bit inj);
    if (b) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wd = wd; b_be = be; b_inj = inj;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wd = wd; a_be = be; a_inj = inj;
    end
    @(negedge clock);
    if (b) begin
      b_req = 1'b0; b_inj = 1'b0;
    end else begin
      a_req = 1'b0; a_inj = 1'b0;
    end
  endtask

  task automatic wr(input bit b, input logic [7:0] addr, input logic [15:0] wd,
                    input logic [1:0] be, input bit inj);
    drive(b, 1'b1, addr, wd, be, inj);
  endtask

  task automatic rd(input bit b, input logic [7:0] addr, input logic [15:0] d,
                    input bit oor, input bit par);
    exp_t e;
    e.d = d; e.oor = oor; e.par = par; e.due = cyc + (b ? 3 : 1);
    if (b) q_b.push_back(e); else q_a.push_back(e);
    drive(b, 1'b0, addr, 16'h0000, 2'b00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nb;
    reset_n = 1'b0;
    a_en = 1'b1; a_req = 1'b0; a_we = 1'b0; a_clr = 1'b0; a_inj = 1'b0;
    a_addr = 8'h00; a_wd = 16'h0000; a_be = 2'b00;
    b_en = 1'b1; b_req = 1'b0; b_we = 1'b0; b_clr = 1'b0; b_inj = 1'b0;
    b_addr = 8'h00; b_wd = 16'h0000; b_be = 2'b00;
    repeat (3) @(negedge clock);
    chk("rst_busy", a_busy, 1'b1);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_valid", a_rv, 1'b0);
    chk("rst_data", a_rd, FILL);
    chk("rst_oor", a_oor, 1'b0);
    chk("rst_par", a_par, 1'b0);
    chk("rst_b_busy", b_busy, 1'b1);

    // Reset release: both sweeps run; A lasts 256 cycles, B lasts 200.
    reset_n = 1'b1;
    n = 0; nb = 0;
    while (a_busy && n < 1000) begin
      if (b_busy) nb++;
      @(negedge clock);
      n++;
    end
    chk("a_sweep_len", n, 256);
    chk("b_sweep_len", nb, 200);
    chk("a_ready_after_sweep", a_ready, 1'b1);

    // Instance A directed traffic.
    rd(0, 8'h10, FILL, 1'b0, 1'b0);
    wr(0, 8'h05, 16'h1234, 2'b11, 1'b0);
    wr(0, 8'h05, 16'hBEEF, 2'b10, 1'b0);
    rd(0, 8'h05, 16'hBE34, 1'b0, 1'b0);
    wr(0, 8'h06, 16'h5678, 2'b01, 1'b0);
    rd(0, 8'h06, 16'hAA78, 1'b0, 1'b0);
    rd(0, 8'h05, 16'hBE34, 1'b0, 1'b0);
    wr(0, 8'h06, 16'hFFFF, 2'b00, 1'b0);
    rd(0, 8'h06, 16'hAA78, 1'b0, 1'b0);
    wr(0, 8'hFF, 16'hCAFE, 2'b11, 1'b0);
    rd(0, 8'hFF, 16'hCAFE, 1'b0, 1'b0);
    rd(0, 8'h00, FILL, 1'b0, 1'b0);
    wr(0, 8'h07, 16'h00FF, 2'b11, 1'b1);
    rd(0, 8'h07, 16'h00FF, 1'b0, PAR_ON);
    wr(0, 8'h07, 16'h0F0F, 2'b11, 1'b0);
    rd(0, 8'h07, 16'h0F0F, 1'b0, 1'b0);
    repeat (2) @(negedge clock);

    // clear_i wins over a simultaneous write request.
    a_clr = 1'b1; a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wd = 16'h1111; a_be = 2'b11;
    #1;
    chk("a_ready_vs_clear", a_ready, 1'b0);
    @(negedge clock);
    a_clr = 1'b0; a_req = 1'b0;
    // The sweep is stretched by a 5-cycle clock-enable gap.
    n = 0;
    while (a_busy && n < 1000) begin
      @(negedge clock);
      n++;
      if (n == 10) a_en = 1'b0;
      if (n == 15) a_en = 1'b1;
    end
    chk("a_clear_len", n, 261);
    rd(0, 8'h05, FILL, 1'b0, 1'b0);
    rd(0, 8'h20, FILL, 1'b0, 1'b0);
    rd(0, 8'hFF, FILL, 1'b0, 1'b0);
    rd(0, 8'h07, FILL, 1'b0, 1'b0);

    // Instance B: latency 3 with back-to-back reads, plus the out-of-range boundary.
    wr(1, 8'h01, 16'h0101, 2'b11, 1'b0);
    wr(1, 8'h02, 16'h0202, 2'b11, 1'b0);
    wr(1, 8'h03, 16'h0303, 2'b11, 1'b0);
    rd(1, 8'h01, 16'h0101, 1'b0, 1'b0);
    rd(1, 8'h02, 16'h0202, 1'b0, 1'b0);
    rd(1, 8'h03, 16'h0303, 1'b0, 1'b0);
    rd(1, 8'hC8, FILL, 1'b1, 1'b0);
    rd(1, 8'hC7, FILL, 1'b0, 1'b0);
    wr(1, 8'hC8, 16'h5555, 2'b11, 1'b0);
    rd(1, 8'h00, FILL, 1'b0, 1'b0);
    rd(1, 8'h01, 16'h0101, 1'b0, 1'b0);
    rd(1, 8'hC7, FILL, 1'b0, 1'b0);
    rd(1, 8'hC8, FILL, 1'b1, 1'b0);
    // A read in flight when a clear starts still returns the pre-clear data.
    rd(1, 8'h02, 16'h0202, 1'b0, 1'b0);
    b_clr = 1'b1;
    @(negedge clock);
    b_clr = 1'b0;
    n = 0;
    while (b_busy && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("b_clear_len", n, 200);
    rd(1, 8'h02, FILL, 1'b0, 1'b0);

    repeat (8) @(negedge clock);
    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
